pm_fetch: RTL

Program-memory fetch sequencer for the 4-bit micro-processor. It owns the program counter and drives read requests into program memory. It waits for the memory acknowledge, then presents each returned instruction nibble to the decode stage through a valid/ready handshake. It is the read-side counterpart of the instruction-holding registers: it generates the addresses and the capture events those registers consume.

---
 rtl/pm_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pm_fetch.sv
// pm_fetch: program-memory fetch sequencer.
// Owns the program counter, issues one-cycle read strobes to program memory,
// waits (bounded) for the acknowledge and hands each returned nibble to the
// decode stage.
//
// Handshake (decode side): an instruction transfers on a rising edge where
// ins_valid_o and ins_ready_i are both high. Once ins_valid_o is raised it
// stays high and ins_o stays stable until that transfer, or until a jump in
// HOLD flushes the buffered instruction.
module pm_fetch #(
    parameter int unsigned          AW       = 8,
    parameter int unsigned          DW       = 4,
    parameter logic [AW-1:0]        RESET_PC = '0,
    parameter int unsigned          TIMEOUT  = 15
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          jmp_i,
    input  logic [AW-1:0] jmp_addr_i,
    output logic [AW-1:0] pm_addr_o,
    output logic          pm_rd_o,
    input  logic          pm_ack_i,
    input  logic [DW-1:0] pm_data_i,
    output logic [DW-1:0] ins_o,
    output logic          ins_valid_o,
    input  logic          ins_ready_i,
    output logic [AW-1:0] pc_o,
    output logic          busy_o,
    output logic          err_o,
    output logic [1:0]    state_o
);

    // Wait counter only has to reach TIMEOUT-1 before the timeout fires.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ins_q, ins_d;
    logic          ins_valid_q, ins_valid_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and datapath registers; clr overrides everything.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and datapath update for the fetch sequence.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // A jump and a fetch start may coincide; the fetch sees the new pc.
                if (jmp_i) pc_d = jmp_addr_i;
                if (en_i)  state_d = ST_REQ;
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pm_ack_i) begin
                    ins_d       = pm_data_i;
                    ins_valid_d = 1'b1;
                    pc_d        = pc_q + AW'(1);
                    state_d     = ST_HOLD;
                end else if (cnt_q == WAIT_LAST) begin
                    // Memory never answered: flag it and leave pc on the failed address.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (jmp_i) begin
                    // Jump flushes the buffered instruction without a transfer.
                    pc_d        = jmp_addr_i;
                    ins_valid_d = 1'b0;
                    state_d     = en_i ? ST_REQ : ST_IDLE;
                end else if (ins_ready_i) begin
                    ins_valid_d = 1'b0;
                    state_d     = en_i ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pm_addr_o   = pc_q;
    assign pc_o        = pc_q;
    assign pm_rd_o     = (state_q == ST_REQ);
    assign busy_o      = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign ins_o       = ins_q;
    assign ins_valid_o = ins_valid_q;
    assign err_o       = err_q;
    assign state_o     = state_q;

endmodule
